// File: rtl/alib_rank_pkg.sv
// rtl/alib_rank_pkg.sv - shared rank-transform constants and state encoding
package alib_rank_pkg;

   localparam int SYMBOL_BITS = 8;
   localparam int TABLE_DEPTH = 256;

   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      LOAD   = 2'd1,
      CHECK  = 2'd2,
      DECODE = 2'd3
   } rank_state_e;

endpackage

// File: rtl/alib_rank_decoder_if.sv
// rtl/alib_rank_decoder_if.sv - table load and decode lane signals of the rank decoder
interface alib_rank_decoder_if
   import alib_rank_pkg::*;
#(
   parameter int N = 8
);
   logic                     i_load_valid;
   logic [SYMBOL_BITS-1:0]   i_load_char;
   logic [SYMBOL_BITS-1:0]   i_load_rank;
   logic                     i_load_done;
   logic                     o_load_ready;
   logic                     i_clear;
   logic [SYMBOL_BITS*N-1:0] i_rank;
   logic [N-1:0]             i_valid;
   logic                     o_ready;
   logic [SYMBOL_BITS*N-1:0] o_char;
   logic [N-1:0]             o_valid;
   logic                     o_error;
   logic                     o_table_ok;

   modport master (
      output i_load_valid, i_load_char, i_load_rank, i_load_done, i_clear, i_rank, i_valid,
      input  o_load_ready, o_ready, o_char, o_valid, o_error, o_table_ok
   );

   modport slave (
      input  i_load_valid, i_load_char, i_load_rank, i_load_done, i_clear, i_rank, i_valid,
      output o_load_ready, o_ready, o_char, o_valid, o_error, o_table_ok
   );

endinterface

// File: rtl/alib_rank_decoder.sv
// rtl/alib_rank_decoder.sv - inverts a char->rank table and decodes N ranks per cycle back to chars
// ALIB_RANK_DECODER_CHECK_EN adds a completeness scan (CHECK state) between LOAD and DECODE.
module alib_rank_decoder
   import alib_rank_pkg::*;
#(
   parameter int NUMBER_OF_PARALLEL_INPUTS = 8
)
(
   input  logic i_clk,
   input  logic i_rst,
   alib_rank_decoder_if.slave bus
);

   localparam int N = NUMBER_OF_PARALLEL_INPUTS;

   rank_state_e              state_q, state_d;
   logic [7:0]               index_q, index_d;
   logic                     error_q, error_d;
   logic [SYMBOL_BITS*N-1:0] char_q, char_d;
   logic [N-1:0]             valid_q, valid_d;

   logic [SYMBOL_BITS-1:0]   inv_table_q [TABLE_DEPTH];
   logic [TABLE_DEPTH-1:0]   written_q;

   logic                     wr_en;
   logic [7:0]               wr_addr;
   logic [SYMBOL_BITS-1:0]   wr_data;
   logic                     wr_mark;

   logic                     decoding;

   assign decoding = (state_q == DECODE) && !bus.i_clear;

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      error_d = error_q;
      valid_d = '0;
      wr_en   = 1'b0;
      wr_addr = index_q;
      wr_data = '0;
      wr_mark = 1'b0;
      if (bus.i_clear) begin
         state_d = CLEAR;
         index_d = 8'd0;
         error_d = 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               wr_en   = 1'b1;
               index_d = index_q + 8'd1;
               if (index_q == 8'hFF) state_d = LOAD;
            end
            LOAD: begin
               if (bus.i_load_valid) begin
                  wr_addr = bus.i_load_rank;
                  // A rank already claimed keeps its first character.
                  if (written_q[bus.i_load_rank]) begin
                     error_d = 1'b1;
                  end else begin
                     wr_en   = 1'b1;
                     wr_data = bus.i_load_char;
                     wr_mark = 1'b1;
                  end
               end
               if (bus.i_load_done) begin
`ifdef ALIB_RANK_DECODER_CHECK_EN
                  state_d = CHECK;
                  index_d = 8'd0;
`else
                  state_d = DECODE;
`endif
               end
            end
`ifdef ALIB_RANK_DECODER_CHECK_EN
            CHECK: begin
               if (!written_q[index_q]) error_d = 1'b1;
               index_d = index_q + 8'd1;
               if (index_q == 8'hFF) state_d = DECODE;
            end
`endif
            DECODE: begin
               valid_d = bus.i_valid;
            end
            default: begin
               state_d = CLEAR;
               index_d = 8'd0;
            end
         endcase
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_lane
      assign char_d[SYMBOL_BITS*j +: SYMBOL_BITS] = decoding
         ? inv_table_q[bus.i_rank[SYMBOL_BITS*j +: SYMBOL_BITS]]
         : char_q[SYMBOL_BITS*j +: SYMBOL_BITS];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= CLEAR;
         index_q <= 8'd0;
         error_q <= 1'b0;
         char_q  <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         error_q <= error_d;
         char_q  <= char_d;
         valid_q <= valid_d;
      end
   end

   // Table storage has no reset; the CLEAR sweep initialises it after every reset.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         inv_table_q[wr_addr] <= wr_data;
         written_q[wr_addr]   <= wr_mark;
      end
   end

   assign bus.o_load_ready = (state_q == LOAD);
   assign bus.o_ready      = (state_q == DECODE);
   assign bus.o_table_ok   = (state_q == DECODE);
   assign bus.o_char       = char_q;
   assign bus.o_valid      = valid_q;
   assign bus.o_error      = error_q;

endmodule
